// File: rtl/fb_pkg.sv
// fb_pkg: shared command encodings, state type and sizing helper for the frame buffer
package fb_pkg;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CLEAR
    } fb_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_sram.sv
// fb_sram: simple dual-port synchronous RAM with one write port and one registered read port
module fb_sram #(
    parameter int DW    = 8,
    parameter int DEPTH = 12288,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // registered read port; the output holds while re is low
    always_ff @(posedge clk)
        if (re) rdata <= mem[raddr];

endmodule

// File: rtl/frame_buffer_rw.sv
// frame_buffer_rw: single-frame pixel store executing WRITE, READ and CLEAR commands over valid/ready streams
module frame_buffer_rw
    import fb_pkg::*;
#(
    parameter int             DW      = 8,
    parameter int             W       = 64,
    parameter int             H       = 64,
    parameter int             CH      = 3,
    parameter logic [DW-1:0]  CLR_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic                         abort,
    input  logic [DW-1:0]                in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DW-1:0]                out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [clog2_min1(CH)-1:0]    out_ch,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int DEPTH = W * H * CH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = clog2_min1(CH);

    fb_state_t     state;
    logic [AW-1:0] ptr;
    logic [CW-1:0] ich, ram_ch;
    logic          rd_end, ram_vld, ram_last;
    logic [DW-1:0] rdata;
    logic          ptr_last, start_ok, wr_beat, clr_beat, load_out, issue, fin;

    // Read path is a two-stage pipe: the RAM output register is the read-ahead slot,
    // out_data is the presented word. The first read is issued on the start cycle.
    always_comb begin
        ptr_last = ptr == AW'(DEPTH - 1);
        start_ok = state == S_IDLE && start && mode != 2'b11;
        wr_beat  = state == S_WRITE && in_valid && !abort;
        clr_beat = state == S_CLEAR && !abort;
        load_out = ram_vld && (!out_valid || out_ready);
        issue    = state == S_READ ? !rd_end && !abort && (!ram_vld || load_out)
                                   : state == S_IDLE && start && mode == MODE_READ;
        fin      = ((wr_beat || clr_beat) && ptr_last) ||
                   (state == S_READ && out_valid && out_ready && out_last && !abort);
    end

    assign in_ready = state == S_WRITE;
    assign busy     = state != S_IDLE;

    // FSM, pointer, read-ahead pipe and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            ich       <= '0;
            ram_ch    <= '0;
            ram_last  <= 1'b0;
            ram_vld   <= 1'b0;
            rd_end    <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fin;
            if (state != S_IDLE && (abort || fin)) begin
                state     <= S_IDLE;
                ptr       <= '0;
                ich       <= '0;
                rd_end    <= 1'b0;
                ram_vld   <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (start_ok)
                    state <= mode == MODE_READ  ? S_READ  :
                             mode == MODE_WRITE ? S_WRITE : S_CLEAR;
                if (wr_beat || clr_beat || issue)
                    ptr <= ptr_last ? ptr : ptr + 1'b1;
                if (issue) begin
                    ich      <= ich == CW'(CH - 1) ? '0 : ich + 1'b1;
                    ram_ch   <= ich;
                    ram_last <= ptr_last;
                    rd_end   <= ptr_last;
                end
                if (load_out) begin
                    out_data <= rdata;
                    out_ch   <= ram_ch;
                    out_last <= ram_last;
                end
                ram_vld   <= issue || (ram_vld && !load_out);
                out_valid <= load_out || (out_valid && !out_ready);
            end
        end
    end

    fb_sram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (wr_beat || clr_beat),
        .waddr (ptr),
        .wdata (state == S_CLEAR ? CLR_VAL : in_data),
        .re    (issue),
        .raddr (ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_frame_buffer_rw.sv
// tb_frame_buffer_rw: self-checking bench for frame_buffer_rw (default size and a small 12-bit mono instance)
module tb_frame_buffer_rw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [11:0] in_data = '0;
    logic        sel = 1'b0;

    logic        in_ready, out_valid, out_last, busy, done;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
    logic [11:0] s_out_data;
    logic [0:0]  s_out_ch;

    int n_chk = 0;
    int n_pass = 0;
    int dp = 12288;
    int nch = 3;
    logic [11:0] msk = 12'h0ff;
    int model [12288];

    always #5 clk = ~clk;

    frame_buffer_rw dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done)
    );

    frame_buffer_rw #(.DW(12), .W(4), .H(2), .CH(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ch(s_out_ch), .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    wire        m_in_ready  = sel ? s_in_ready  : in_ready;
    wire        m_out_valid = sel ? s_out_valid : out_valid;
    wire        m_last      = sel ? s_out_last  : out_last;
    wire        m_busy      = sel ? s_busy      : busy;
    wire        m_done      = sel ? s_done      : done;
    wire [11:0] m_data      = sel ? s_out_data  : {4'b0, out_data};
    wire [1:0]  m_ch        = sel ? {1'b0, s_out_ch} : out_ch;

    typedef struct {
        logic [1:0] mode;
        logic       start;
        logic       exp_busy;
        logic       exp_in_ready;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmd(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic do_write(input int n, input bit toggle, input bit rnd);
        int i = 0;
        int cyc = 0;
        logic [11:0] d;
        logic rdy;
        cmd(2'b01);
        chk("wr_in_ready", m_in_ready, 1);
        while (i < n && cyc < 4 * n + 20) begin
            d        = rnd ? 12'($urandom) & msk : 12'(i) & msk;
            in_data  = d;
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            rdy      = m_in_ready;
            step();
            cyc++;
            if (in_valid && rdy) begin
                model[i] = int'(d);
                i++;
            end
        end
        in_valid = 1'b0;
        chk("wr_beats", i, n);
        if (n == dp) begin
            chk("wr_done", m_done, 1);
            chk("wr_idle", m_busy, 0);
        end else begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("wr_abort_busy", m_busy, 0);
            chk("wr_abort_done", m_done, 0);
        end
        step();
        chk("wr_done_low", m_done, 0);
    endtask

    task automatic do_read(input bit rnd, input int n, input bit kill_rst);
        int idx = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic v;
        logic [31:0] cur, prev, exp;
        prev = '0;
        out_ready = 1'b1;
        cmd(2'b00);
        chk("rd_busy", m_busy, 1);
        chk("rd_valid_c1", m_out_valid, 0);
        step();
        chk("rd_valid_c2", m_out_valid, 1);
        while (idx < n && cyc < 4 * dp + 20) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {17'b0, m_last, m_ch, m_data};
            if (stall) chk("rd_hold", cur, prev);
            v = m_out_valid;
            if (v && out_ready) begin
                exp = {17'b0, 1'(idx == dp - 1), 2'(idx % nch), 12'(model[idx])};
                chk("rd_beat", cur, exp);
                idx++;
            end
            stall = v && !out_ready;
            prev  = cur;
            step();
            cyc++;
        end
        chk("rd_beats", idx, n);
        out_ready = 1'b1;
        if (n == dp) begin
            if (!rnd) chk("rd_cycles", cyc, dp);
            chk("rd_done", m_done, 1);
            chk("rd_idle", m_busy, 0);
            chk("rd_valid_end", m_out_valid, 0);
            step();
            chk("rd_done_low", m_done, 0);
        end else if (kill_rst) begin
            #3 rst_n = 1'b0;
            #2;
            chk("rst_valid", m_out_valid, 0);
            chk("rst_busy", m_busy, 0);
            chk("rst_done", m_done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            step();
        end else begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("rd_abort_valid", m_out_valid, 0);
            chk("rd_abort_busy", m_busy, 0);
            chk("rd_abort_done", m_done, 0);
        end
    endtask

    initial begin
        vec_t vecs [5];
        int cnt;
        vecs[0] = '{2'b00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            chk("rst_in_ready", m_in_ready, 0);
            chk("rst_out_valid", m_out_valid, 0);
            chk("rst_out_data", m_data, 0);
            chk("rst_out_ch", m_ch, 0);
            chk("rst_out_last", m_last, 0);
            chk("rst_busy", m_busy, 0);
            chk("rst_done", m_done, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 5; k++) begin
            start = vecs[k].start;
            mode  = vecs[k].mode;
            step();
            start = 1'b0;
            chk("vec_busy", m_busy, vecs[k].exp_busy);
            chk("vec_in_ready", m_in_ready, vecs[k].exp_in_ready);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("vec_abort_busy", m_busy, 0);
            chk("vec_abort_done", m_done, 0);
        end

        cmd(2'b10);
        chk("clr_busy", m_busy, 1);
        cnt = 0;
        while (!m_done && cnt < dp + 10) begin
            start = (cnt == 5);
            mode  = 2'b00;
            step();
            cnt++;
        end
        start = 1'b0;
        chk("clr_cycles", cnt, dp);
        chk("clr_idle", m_busy, 0);
        for (int i = 0; i < dp; i++) model[i] = 0;

        do_write(100, 1'b0, 1'b1);
        do_read(1'b0, dp, 1'b0);
        do_write(dp, 1'b1, 1'b0);
        do_read(1'b1, dp, 1'b0);
        do_read(1'b0, 10, 1'b1);
        do_read(1'b0, 20, 1'b0);

        sel = 1'b1;
        dp  = 8;
        nch = 1;
        msk = 12'hfff;
        #1;
        do_write(8, 1'b0, 1'b1);
        do_read(1'b1, 8, 1'b0);
        do_read(1'b0, 3, 1'b1);
        do_read(1'b0, 8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
